qimag_serial_adder: RTL and testbench

- Digit-serial adder for quater-imaginary (base 2i, digits 0..3) operands.
- Loads two DIGITS-digit operands in parallel and produces one result digit per clock, LSD first.
- Routes each digit's signed carry two positions up, since (2i)^2 = -4.
- Sits directly upstream of result consumers (complex display/convert stages). It is the sequencing stage wrapped around the per-digit quater-imaginary full-add rule.

---
 rtl/qimag_serial_adder.sv | 104 ++++++++++
 tb/tb_qimag_serial_adder.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/qimag_serial_adder.sv
// Digit-serial quater-imaginary (base 2i) adder: one result digit per clock, LSD first.
// Optional early termination of RUN when no carries remain: define QIMAG_SERIAL_EARLY_DONE_EN.
module qimag_serial_adder #(
    parameter int DIGITS = 8,
    parameter int EXTRA  = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [2*DIGITS-1:0]             a,
    input  logic [2*DIGITS-1:0]             b,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [2*(DIGITS+EXTRA)-1:0]     sum,
    output logic                            overflow
);
    localparam int N  = DIGITS + EXTRA;
    localparam int CW = $clog2(N) + 1;
    localparam logic [CW-1:0] LAST    = CW'(N - 1);
    localparam logic [CW-1:0] EARLY_K = CW'(DIGITS - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]            state;
    logic [CW-1:0]         cnt;
    logic [2*DIGITS-1:0]   a_sh, b_sh;
    // Carry delay line, each entry {cp, cn}: dl1 from digit k-1, dl2 from digit k-2.
    logic [1:0]            dl1, dl2;
    logic [2*N-1:0]        sum_r;
    logic                  ovf_r;
    logic [3:0]            t;
    logic [1:0]            cout;
    logic                  fin;

    // Operand registers shift right with zero fill, so digits at k >= DIGITS read as 0.
    always_comb begin
        t    = 4'(a_sh[1:0]) + 4'(b_sh[1:0]) + 4'(dl2[1]) - 4'(dl2[0]);
        // t = -1 wraps to 4'hF: digit 3 with +1 carry; t in 4..7: digit t-4 with -1 carry.
        cout = {t == 4'hF, t[3:2] == 2'b01};
        fin  = (cnt == LAST);
`ifdef QIMAG_SERIAL_EARLY_DONE_EN
        if (cnt >= EARLY_K && cout == 2'b00 && dl1 == 2'b00)
            fin = 1'b1;
`else
        fin  = fin | 1'b0;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            cnt   <= '0;
            a_sh  <= '0;
            b_sh  <= '0;
            dl1   <= '0;
            dl2   <= '0;
            sum_r <= '0;
            ovf_r <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        dl1   <= '0;
                        dl2   <= '0;
                        sum_r <= '0;
                        ovf_r <= 1'b0;
                        cnt   <= '0;
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    a_sh <= a_sh >> 2;
                    b_sh <= b_sh >> 2;
                    for (int i = 0; i < N; i++)
                        if (cnt == CW'(i))
                            sum_r[2*i +: 2] <= t[1:0];
                    dl2 <= dl1;
                    dl1 <= cout;
                    cnt <= cnt + CW'(1);
                    if (fin) begin
                        // Anything still in flight would land above the top result digit.
                        ovf_r <= |{cout, dl1};
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready)
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);
    assign sum       = sum_r;
    assign overflow  = ovf_r;
endmodule

// File: tb/tb_qimag_serial_adder.sv
// Self-checking bench for qimag_serial_adder: EXTRA=4 and EXTRA=0 instances against a value-level model.
module tb_qimag_serial_adder;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] a = '0, b = '0;
    logic        iv = 1'b0, ordy = 1'b0, iv0 = 1'b0, ordy0 = 1'b0;
    logic        irdy, ov, ovf, irdy0, ov0, ovf0;
    logic [23:0] sm;
    logic [15:0] sm0;
    int          total = 0, bad = 0;

    always #5 clk = ~clk;

    qimag_serial_adder #(.DIGITS(8), .EXTRA(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(iv), .in_ready(irdy), .a(a), .b(b),
        .out_valid(ov), .out_ready(ordy), .sum(sm), .overflow(ovf));

    qimag_serial_adder #(.DIGITS(8), .EXTRA(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv0), .in_ready(irdy0), .a(a), .b(b),
        .out_valid(ov0), .out_ready(ordy0), .sum(sm0), .overflow(ovf0));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Complex value of an 8-digit base-2i number: even digits weigh (-4)^j, odd digits 2i*(-4)^j.
    function automatic void qval(input logic [15:0] v, output int re, output int im);
        int pw = 1;
        re = 0; im = 0;
        for (int j = 0; j < 4; j++) begin
            re += int'(v[4*j +: 2]) * pw;
            im += 2 * int'(v[4*j+2 +: 2]) * pw;
            pw *= -4;
        end
    endfunction

    // Base -4 digits of an integer, least significant first.
    function automatic void negq(input int x, output int d[16]);
        int r;
        for (int j = 0; j < 16; j++) begin
            r = x % 4;
            if (r < 0) r += 4;
            d[j] = r;
            x = (x - r) / -4;
        end
    endfunction

    // Sum in base 2i = real part in base -4 on even digits, imag/2 in base -4 on odd digits.
    function automatic void model(input logic [15:0] aa, input logic [15:0] bb, input int n,
                                  output logic [23:0] es, output logic eo, output int el);
        int ra, ia, rb, ib, h;
        int dr[16], di[16], dg[32];
        qval(aa, ra, ia);
        qval(bb, rb, ib);
        negq(ra + rb, dr);
        negq((ia + ib) / 2, di);
        for (int j = 0; j < 16; j++) begin
            dg[2*j]   = dr[j];
            dg[2*j+1] = di[j];
        end
        es = '0; eo = 1'b0; h = -1;
        for (int k = 0; k < 32; k++) begin
            if (dg[k] != 0) h = k;
            if (k < n) es[2*k +: 2] = 2'(dg[k]);
            else if (dg[k] != 0) eo = 1'b1;
        end
        el = n;
`ifdef QIMAG_SERIAL_EARLY_DONE_EN
        if (h + 1 <= 8) el = 8;
        else if (h + 1 < n) el = h + 1;
`endif
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic start(input bit sel, input logic [15:0] aa, input logic [15:0] bb, input string tag);
        a = aa; b = bb;
        chk({tag, " in_ready"}, sel ? irdy0 : irdy, 1'b1);
        if (sel) iv0 = 1'b1; else iv = 1'b1;
        step();
        iv = 1'b0; iv0 = 1'b0;
        a = 16'($urandom); b = 16'($urandom);
    endtask

    task automatic wait_done(input bit sel, input logic [15:0] aa, input logic [15:0] bb, input string tag);
        logic [23:0] es;
        logic        eo;
        int          el, lat;
        model(aa, bb, sel ? 8 : 12, es, eo, el);
        lat = 0;
        do begin
            step();
            lat++;
        end while (!(sel ? ov0 : ov) && lat < 40);
        chk({tag, " latency"}, lat, el);
        chk({tag, " sum"}, sel ? {8'h0, sm0} : sm, es);
        chk({tag, " overflow"}, sel ? ovf0 : ovf, eo);
    endtask

    task automatic handshake(input bit sel, input string tag);
        if (sel) ordy0 = 1'b1; else ordy = 1'b1;
        step();
        ordy = 1'b0; ordy0 = 1'b0;
        chk({tag, " valid drop"}, sel ? ov0 : ov, 1'b0);
        chk({tag, " idle"}, sel ? irdy0 : irdy, 1'b1);
    endtask

    task automatic op(input bit sel, input logic [15:0] aa, input logic [15:0] bb, input string tag);
        start(sel, aa, bb, tag);
        wait_done(sel, aa, bb, tag);
        handshake(sel, tag);
    endtask

    initial begin
        logic [23:0] hs;
        logic        ho;
        logic [15:0] ra, rb;

        #2;
        chk("rst in_ready", irdy, 1'b1);
        chk("rst out_valid", ov, 1'b0);
        chk("rst sum", sm, 24'h0);
        chk("rst overflow", ovf, 1'b0);
        step();
        rst_n = 1'b1;
        step();

        op(1'b0, 16'h0001, 16'h0003, "basic");
        op(1'b0, 16'h8000, 16'h8000, "topcarry x4");
        op(1'b1, 16'h8000, 16'h8000, "topcarry x0");
        op(1'b0, 16'h0000, 16'h0000, "zero");
        op(1'b1, 16'hFFFF, 16'hFFFF, "ones x0");
        op(1'b0, 16'hFFFF, 16'hFFFF, "ones x4");

        // Backpressure: result must hold while out_ready is low; a new offer is ignored.
        start(1'b0, 16'h0001, 16'h0003, "bp");
        wait_done(1'b0, 16'h0001, 16'h0003, "bp");
        hs = sm; ho = ovf;
        for (int i = 0; i < 5; i++) begin
            iv = (i == 2);
            a = 16'h1234; b = 16'h4321;
            step();
            chk("bp valid hold", ov, 1'b1);
            chk("bp in_ready low", irdy, 1'b0);
            chk("bp sum hold", sm, hs);
            chk("bp ovf hold", ovf, ho);
        end
        iv = 1'b0;
        handshake(1'b0, "bp");
        step(); step();
        chk("bp no phantom", ov, 1'b0);
        chk("bp still idle", irdy, 1'b1);

        // Reset while the counter sits at digit 3.
        start(1'b0, 16'h8000, 16'h8000, "rst run");
        step(); step(); step();
        #1 rst_n = 1'b0;
        #1;
        chk("midrun in_ready", irdy, 1'b1);
        chk("midrun out_valid", ov, 1'b0);
        chk("midrun sum", sm, 24'h0);
        chk("midrun overflow", ovf, 1'b0);
        step();
        rst_n = 1'b1;
        step();
        op(1'b0, 16'h0001, 16'h0003, "post rst");

        for (int i = 0; i < 25; i++) begin
            ra = 16'($urandom); rb = 16'($urandom);
            op(1'(i % 2), ra, rb, $sformatf("rand%0d", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
